ym_frame_fifo: RTL
==================

# ym_frame_fifo

Sample-pairing and buffering controller placed after the YM2151 serial-to-parallel converter in the ym09 capture path. It detects the rising edges of the converter's per-channel update strobes and pairs each right sample with the next left sample into a stereo frame. Completed frames go into a first-word-fall-through FIFO that a host or DAC drains through a valid/ready handshake. Overflow, pairing errors and dropped frames are reported through sticky flags and counters.

## Interface
Parameters:
- DEPTH, 8: FIFO depth in frames; power of two, minimum 2.
- DW, 16: sample width per channel.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  reset, asynchronous, active-high.
- enable  in  1  capture enable; low stops new frame assembly.
- flush  in  1  synchronous clear of FIFO, pairing state, flags and counters.
- left  in  DW  left sample from the converter.
- right  in  DW  right sample from the converter.
- update_left  in  1  left strobe; level, may stay high for many clk cycles.
- update_right  in  1  right strobe; same rules as update_left.
- frame_valid  out  1  FIFO non-empty.
- frame_ready  in  1  consumer accepts the head frame.
- frame_left  out  DW  head frame, left sample.
- frame_right  out  DW  head frame, right sample.
- level  out  $clog2(DEPTH)+1  frames stored, 0..DEPTH.
- overflow  out  1  sticky; a frame was dropped because the FIFO was full.
- pair_err  out  1  sticky; a channel arrived twice without its partner.
- drop_cnt  out  8  dropped-frame count, saturates at 255.

## Operation
- Edge detect:
  - Registered copies of update_left and update_right are kept.
  - An event is the input high in this cycle and low in the previous cycle.
  - The sample value is taken from left or right in the event cycle.
  - Edge registers reset to 0, so an input that is high straight out of reset produces an event.
- Pairing FSM, states WAIT, HAVE_R, HAVE_L (reset and flush to WAIT):
  - WAIT:
    - R event only: hold right, go to HAVE_R.
    - L event only: hold left, go to HAVE_L.
    - Both events in one cycle: push a frame with both current values, stay in WAIT.
  - HAVE_R:
    - L event: push {left, held right}, go to WAIT.
    - R event without L: replace held right, set pair_err, stay.
    - L and R events together: push {left, held right}, hold the new right, stay in HAVE_R.
  - HAVE_L: mirror of HAVE_R with the channels swapped.
  - enable low: no events are recognised; the FSM is forced to WAIT and held samples are discarded. Edge registers keep tracking the inputs, so re-enabling while a strobe is high produces no spurious event.
- FIFO:
  - DEPTH x 2·DW storage with read/write pointers that wrap modulo DEPTH, plus the level counter.
  - Push when level < DEPTH, or when level = DEPTH and a pop happens in the same cycle.
  - Otherwise the push is discarded: set overflow and increment drop_cnt, saturating at 255.
  - Pop when frame_valid & frame_ready. A pop while empty is ignored.
  - Simultaneous push and pop: level is unchanged and both pointers advance.
  - frame_left and frame_right always show the head entry; they are don't-care while frame_valid = 0.
- flush: takes priority over every other action in its cycle. It empties the FIFO and clears the FSM, overflow, pair_err and drop_cnt. A strobe edge in the flush cycle is lost.

## Timing
- Reset values:
  - frame_valid = 0, level = 0, overflow = 0, pair_err = 0, drop_cnt = 0.
  - frame_left = 0, frame_right = 0.
  - FSM = WAIT, pointers = 0.
- Latency from the completing event to visibility:
  - Event sampled at edge n; frame written at edge n.
  - frame_valid = 1 and head data valid after edge n when the FIFO was empty.
  - level updates at edge n.
- Pop at edge n: the next head appears after edge n. frame_valid drops after edge n if level was 1 and no push happened.
- Flags and drop_cnt update on the same edge as the rejected push.
- Throughput: one push and one pop per clk cycle.

## Test plan
- Reset and basic pair:
  - Stimulus: rst pulse; right=0x1234 strobe held high for 5 cycles; left=0xABCD strobe.
  - Required: exactly one frame {0xABCD, 0x1234}; frame_valid rises one edge after the left edge; level = 1; pair_err = 0.
- Simultaneous strobes:
  - Stimulus: update_left and update_right rise on the same cycle with L=1, R=2.
  - Required: one frame {1, 2}; FSM returns to WAIT.
- Pair error:
  - Stimulus: R=5, R=6, then L=7.
  - Required: pair_err = 1; single frame {7, 6}.
- Overflow:
  - Stimulus: frame_ready = 0; push DEPTH+3 frames.
  - Required: level = 8; overflow = 1; drop_cnt = 3; the drained order holds the first 8 frames in order.
- Full with concurrent pop:
  - Stimulus: FIFO full; frame_ready = 1 in the same cycle as a push.
  - Required: push accepted; level stays 8; overflow unchanged.
- Enable and flush:
  - Stimulus: enable low during R, then high before L. Separately, assert flush with 3 frames queued.
  - Required (enable case): no frame is produced.
  - Required (flush case): level = 0; frame_valid = 0; flags cleared on the next edge.

Source files
------------

// File: rtl/ym_frame_fifo.sv
// ---------------------------------------------------------------------------
// ym_frame_fifo
//
// Pairs the YM2151 converter's right/left channel samples into stereo frames
// and buffers them in a first-word-fall-through FIFO drained by valid/ready.
//
// Ports
//   clk, rst          : system clock, asynchronous active-high reset
//   enable            : capture enable; low stops frame assembly
//   flush             : synchronous clear of FIFO, pairing state, flags, counter
//   left, right       : converter samples (DW bits each)
//   update_left/right : level strobes; a rising edge marks a new sample
//   frame_valid       : FIFO non-empty
//   frame_ready       : consumer accepts the head frame
//   frame_left/right  : head frame samples (zero while empty)
//   level             : frames stored, 0..DEPTH
//   overflow          : sticky, a frame was dropped on a full FIFO
//   pair_err          : sticky, a channel arrived twice without its partner
//   drop_cnt          : dropped-frame count, saturating at 255
// ---------------------------------------------------------------------------
module ym_frame_fifo #(
  parameter int DEPTH = 8,
  parameter int DW    = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic                       flush,
  input  logic [DW-1:0]              left,
  input  logic [DW-1:0]              right,
  input  logic                       update_left,
  input  logic                       update_right,
  output logic                       frame_valid,
  input  logic                       frame_ready,
  output logic [DW-1:0]              frame_left,
  output logic [DW-1:0]              frame_right,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow,
  output logic                       pair_err,
  output logic [7:0]                 drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  // Pairing FSM encoding
  localparam logic [1:0] ST_WAIT   = 2'd0;
  localparam logic [1:0] ST_HAVE_R = 2'd1;
  localparam logic [1:0] ST_HAVE_L = 2'd2;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic          ul_q, ul_d;
  logic          ur_q, ur_d;
  logic [1:0]    state_q, state_d;
  logic [DW-1:0] hold_q, hold_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          overflow_q, overflow_d;
  logic          pair_err_q, pair_err_d;
  logic [7:0]    drop_cnt_q, drop_cnt_d;

  logic [2*DW-1:0] mem_q [DEPTH];

  // -------------------------------------------------------------------------
  // Edge detection
  // -------------------------------------------------------------------------
  logic ev_l, ev_r;

  // The edge registers follow the strobes even while disabled or flushing, so
  // a strobe that is already high when capture resumes is not seen as an edge.
  assign ul_d = update_left;
  assign ur_d = update_right;
  assign ev_l = enable & update_left  & ~ul_q;
  assign ev_r = enable & update_right & ~ur_q;

  // -------------------------------------------------------------------------
  // Pairing FSM
  // -------------------------------------------------------------------------
  logic          push;
  logic [DW-1:0] push_l;
  logic [DW-1:0] push_r;
  logic          set_pair_err;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    state_d      = state_q;
    hold_d       = hold_q;
    push         = 1'b0;
    push_l       = left;
    push_r       = right;
    set_pair_err = 1'b0;

    if (!enable) begin
      state_d = ST_WAIT;
      hold_d  = '0;
    end else begin
      case (state_q)
        ST_WAIT: begin
          if (ev_l && ev_r) begin
            push = 1'b1;
          end else if (ev_r) begin
            hold_d  = right;
            state_d = ST_HAVE_R;
          end else if (ev_l) begin
            hold_d  = left;
            state_d = ST_HAVE_L;
          end
        end
        ST_HAVE_R: begin
          if (ev_l) begin
            push   = 1'b1;
            push_r = hold_q;
            // A right edge alongside the completing left starts the next pair.
            if (ev_r) hold_d = right;
            else      state_d = ST_WAIT;
          end else if (ev_r) begin
            hold_d       = right;
            set_pair_err = 1'b1;
          end
        end
        ST_HAVE_L: begin
          if (ev_r) begin
            push   = 1'b1;
            push_l = hold_q;
            if (ev_l) hold_d = left;
            else      state_d = ST_WAIT;
          end else if (ev_l) begin
            hold_d       = left;
            set_pair_err = 1'b1;
          end
        end
        default: begin
          state_d = ST_WAIT;
          hold_d  = '0;
        end
      endcase
    end

    if (flush) begin
      state_d = ST_WAIT;
      hold_d  = '0;
    end
  end

  // -------------------------------------------------------------------------
  // FIFO control
  // -------------------------------------------------------------------------
  logic pop;
  logic push_ok;
  logic wr_en;

  assign pop     = frame_valid & frame_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok = push & ((level_q != DEPTH_L) | pop);
  assign wr_en   = push_ok & ~flush;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;
    pair_err_d = pair_err_q | set_pair_err;
    drop_cnt_d = drop_cnt_q;

    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);

    case ({push_ok, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    if (push && !push_ok) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
    end

    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      level_d    = '0;
      overflow_d = 1'b0;
      pair_err_d = 1'b0;
      drop_cnt_d = '0;
    end
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ul_q       <= 1'b0;
      ur_q       <= 1'b0;
      state_q    <= ST_WAIT;
      hold_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      pair_err_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      ul_q       <= ul_d;
      ur_q       <= ur_d;
      state_q    <= state_d;
      hold_q     <= hold_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      pair_err_q <= pair_err_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // NOTE: the frame storage has no reset; entries are only read once written,
  // and the head output is masked to zero while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= {push_l, push_r};
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  logic [2*DW-1:0] head;

  assign head        = mem_q[rd_ptr_q];
  assign frame_valid = (level_q != '0);
  assign frame_left  = frame_valid ? head[2*DW-1:DW] : '0;
  assign frame_right = frame_valid ? head[DW-1:0]    : '0;
  assign level       = level_q;
  assign overflow    = overflow_q;
  assign pair_err    = pair_err_q;
  assign drop_cnt    = drop_cnt_q;

endmodule
